// File: rtl/d6809_pkg.sv
// d6809_pkg: shared definitions for the d6809 memory fetch path.
// Holds default bus widths, the fetch sequencer state encoding and the
// register-file destination slot indices used by CtrlUnit requests.
package d6809_pkg;

    // Default widths for the fetch path
    localparam int unsigned D6809_ADDR_W  = 16;
    localparam int unsigned D6809_DATA_W  = 8;
    localparam int unsigned D6809_LEN_W   = 3;
    localparam int unsigned D6809_DST_W   = 4;
    localparam int unsigned D6809_TIMEOUT = 15;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    // Register-file destination slots; 16-bit registers use a high/low pair
    // so a big-endian burst lands high byte first.
    localparam logic [D6809_DST_W-1:0] DST_IR  = 4'd0;
    localparam logic [D6809_DST_W-1:0] DST_ARH = 4'd1;
    localparam logic [D6809_DST_W-1:0] DST_ARL = 4'd2;
    localparam logic [D6809_DST_W-1:0] DST_T   = 4'd3;
    localparam logic [D6809_DST_W-1:0] DST_A   = 4'd4;
    localparam logic [D6809_DST_W-1:0] DST_B   = 4'd5;
    localparam logic [D6809_DST_W-1:0] DST_XH  = 4'd6;
    localparam logic [D6809_DST_W-1:0] DST_XL  = 4'd7;
    localparam logic [D6809_DST_W-1:0] DST_YH  = 4'd8;
    localparam logic [D6809_DST_W-1:0] DST_YL  = 4'd9;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: counts consecutive wait cycles of a pending memory read
// and flags the cycle in which the count would reach TIMEOUT.
// Ports:
//   clk, reset  - clock, async active-low reset
//   en          - a wait cycle is in progress (read pending, no ack)
//   clr         - restart the count (ack seen or not reading)
//   expire_c    - combinational: this wait cycle hits the TIMEOUT bound
// TIMEOUT = 0 disables expiry entirely.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expire_c
);

    localparam int unsigned   CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [CW-1:0] cnt;

    // cnt holds the number of wait cycles already seen
    assign expire_c = (TIMEOUT != 0) && en && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || expire_c) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_fetch_seq.sv
// mem_fetch_seq: handshaked multi-byte fetch sequencer. Reads req_len
// consecutive bytes from a wait-stated memory port and writes them,
// big-endian, to consecutive register-file slots starting at req_dst.
// Ports:
//   clk, reset                       - clock, async active-low reset
//   req_valid/req_ready              - request handshake (ready = IDLE)
//   req_addr, req_len, req_dst       - first address, byte count, first slot
//   mem_rd, mem_addr                 - read strobe/address, held until ack
//   mem_rdata, mem_ack               - read data and completion
//   wr_en, wr_dst, wr_data           - register-file write, one cycle per byte
//   done, err                        - burst-complete pulse, timeout flag
//   next_addr                        - address after last acked byte
//   busy                             - sequencer not idle
module mem_fetch_seq
    import d6809_pkg::*;
#(
    parameter int unsigned ADDR_W  = D6809_ADDR_W,
    parameter int unsigned DATA_W  = D6809_DATA_W,
    parameter int unsigned LEN_W   = D6809_LEN_W,
    parameter int unsigned DST_W   = D6809_DST_W,
    parameter int unsigned TIMEOUT = D6809_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DST_W-1:0]  req_dst,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wr_en,
    output logic [DST_W-1:0]  wr_dst,
    output logic [DATA_W-1:0] wr_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] next_addr,
    output logic              busy
);

    fetch_state_e     state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic [DST_W-1:0]  dst;
    logic              wait_c;
    logic              expire_c;

    assign req_ready = (state == ST_IDLE);
    assign mem_addr  = addr;
    assign wait_c    = (state == ST_READ) && !mem_ack;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .en       (wait_c),
        .clr      (!wait_c),
        .expire_c (expire_c)
    );

    // Sequencer FSM with registered outputs; wr_en/done/err are pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            dst       <= '0;
            mem_rd    <= 1'b0;
            wr_en     <= 1'b0;
            wr_dst    <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            next_addr <= '0;
            busy      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr      <= req_addr;
                        remaining <= req_len;
                        dst       <= req_dst;
                        busy      <= 1'b1;
                        if (req_len == '0) begin
                            // Empty burst completes without touching memory
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            next_addr <= req_addr;
                        end else begin
                            state  <= ST_READ;
                            mem_rd <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (mem_ack) begin
                        wr_en     <= 1'b1;
                        wr_data   <= mem_rdata;
                        wr_dst    <= dst;
                        addr      <= addr + ADDR_W'(1);
                        dst       <= dst + DST_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state     <= ST_DONE;
                            mem_rd    <= 1'b0;
                            done      <= 1'b1;
                            next_addr <= addr + ADDR_W'(1);
                        end
                    end else if (expire_c) begin
                        // Abort: pending byte is dropped, earlier writes stand
                        state     <= ST_DONE;
                        mem_rd    <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        next_addr <= addr;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    mem_rd <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fetch_seq.sv
// tb_mem_fetch_seq: table-driven bench for mem_fetch_seq with a byte memory
// model and a per-byte wait-state responder, plus a mid-burst reset sequence.
module tb_mem_fetch_seq;
    import d6809_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [2:0]  req_len;
    logic [3:0]  req_dst;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        wr_en;
    logic [3:0]  wr_dst;
    logic [7:0]  wr_data;
    logic        done;
    logic        err;
    logic [15:0] next_addr;
    logic        busy;

    mem_fetch_seq dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_dst   (req_dst),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .wr_en     (wr_en),
        .wr_dst    (wr_dst),
        .wr_data   (wr_data),
        .done      (done),
        .err       (err),
        .next_addr (next_addr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  len;
        logic [3:0]  dst;
        int          waits;     // wait cycles before each ack
        int          acks;      // bytes the responder will ack
        bit          hold;      // keep req_valid high with junk fields
        int          done_cyc;  // cycle of done, accept edge = 0
        bit          exp_err;
        logic [15:0] exp_next;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] mem  [0:65535];
    int         n_total;
    int         n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Issue one request from IDLE (called #1 after a posedge) and follow it to done
    task automatic run_vec(input int idx, input vec_t v);
        int          wr_i;
        int          rd_cyc;
        int          acked;
        int          wcnt;
        bit          done_seen;
        logic [15:0] ea;
        logic [3:0]  ed;
        wr_i = 0; rd_cyc = 0; acked = 0; wcnt = 0; done_seen = 0;
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_len   = v.len;
        req_dst   = v.dst;
        @(posedge clk); #1;
        if (v.hold) begin
            req_addr = 16'hDEAD;
            req_len  = 3'd5;
            req_dst  = 4'hC;
        end else begin
            req_valid = 1'b0;
        end
        chk($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
        chk($sformatf("v%0d req_ready_low", idx), 32'(req_ready), 32'd0);
        for (int c = 1; c <= 200 && !done_seen; c++) begin
            if (mem_rd) begin
                rd_cyc++;
                ea = v.addr + 16'(acked);
                chk($sformatf("v%0d c%0d mem_addr", idx, c), 32'(mem_addr), 32'(ea));
            end
            if (wr_en) begin
                ea = v.addr + 16'(wr_i);
                ed = v.dst + 4'(wr_i);
                chk($sformatf("v%0d wr%0d dst", idx, wr_i), 32'(wr_dst), 32'(ed));
                chk($sformatf("v%0d wr%0d data", idx, wr_i), 32'(wr_data), 32'(mem[ea]));
                wr_i++;
            end
            if (done) begin
                done_seen = 1;
                req_valid = 1'b0;
                mem_ack   = 1'b0;
                chk($sformatf("v%0d done_cycle", idx), 32'(c), 32'(v.done_cyc));
                chk($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
                chk($sformatf("v%0d next_addr", idx), 32'(next_addr), 32'(v.exp_next));
                chk($sformatf("v%0d mem_rd_at_done", idx), 32'(mem_rd), 32'd0);
                chk($sformatf("v%0d wr_en_at_done", idx), 32'(wr_en),
                    32'((v.len != 3'd0) && !v.exp_err));
            end else begin
                if (mem_rd && acked < v.acks && wcnt == v.waits) begin
                    ea        = v.addr + 16'(acked);
                    mem_ack   = 1'b1;
                    mem_rdata = mem[ea];
                    acked++;
                    wcnt = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 8'h00;
                    if (mem_rd) wcnt++;
                end
                @(posedge clk); #1;
            end
        end
        if (!done_seen) chk($sformatf("v%0d done_seen", idx), 32'd0, 32'd1);
        chk($sformatf("v%0d wr_count", idx), 32'(wr_i), 32'(v.acks));
        chk($sformatf("v%0d mem_rd_cycles", idx), 32'(rd_cyc), 32'(v.done_cyc - 1));
        @(posedge clk); #1;
        chk($sformatf("v%0d ready_after", idx), 32'(req_ready), 32'd1);
        chk($sformatf("v%0d idle_after", idx), 32'({busy, done, wr_en, mem_rd}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 7 + 3) ^ (i >> 8));
        mem[16'h0100] = 8'h8E;
        mem[16'h0101] = 8'h12;
        mem[16'hFFFF] = 8'hA5;
        mem[16'h0000] = 8'h5A;

        //            addr      len   dst      wt ack hold done err next
        vecs[0] = '{16'h0100, 3'd2, DST_XH, 0, 2, 0,   3, 0, 16'h0102};
        vecs[1] = '{16'h2000, 3'd1, DST_A,  3, 1, 0,   5, 0, 16'h2001};
        vecs[2] = '{16'hFFFF, 3'd2, 4'd15,  0, 2, 0,   3, 0, 16'h0001};
        vecs[3] = '{16'h3000, 3'd3, DST_T,  0, 1, 0,  17, 1, 16'h3001};
        vecs[4] = '{16'h4000, 3'd0, DST_B,  0, 0, 0,   1, 0, 16'h4000};
        vecs[5] = '{16'h5000, 3'd7, DST_YL, 1, 7, 1,  15, 0, 16'h5007};

        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_dst   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset ctrl", 32'({mem_rd, wr_en, done, err, busy}), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset wr_bus", 32'({wr_dst, wr_data}), 32'd0);
        chk("reset next_addr", 32'(next_addr), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset in the 2nd READ cycle of a len-4 burst
        req_valid = 1'b1;
        req_addr  = 16'h6000;
        req_len   = 3'd4;
        req_dst   = DST_IR;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = mem[16'h6000];
        @(posedge clk); #1;
        chk("rst pre mem_rd", 32'(mem_rd), 32'd1);
        chk("rst pre wr_en", 32'(wr_en), 32'd1);
        reset   = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("rst mem_rd", 32'(mem_rd), 32'd0);
        chk("rst wr_en", 32'(wr_en), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst hold%0d done", i), 32'(done), 32'd0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post rst done", 32'(done), 32'd0);
        chk("post rst req_ready", 32'(req_ready), 32'd1);
        run_vec(6, vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
